// File: rtl/complement_pkg.sv
// Shared mode encodings and FSM state type for the serial sign-representation converter.
package complement_pkg;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_SM2OC = 2'b01;
  localparam logic [1:0] MODE_SM2TC = 2'b10;
  localparam logic [1:0] MODE_TC2SM = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/complement_bit_cell.sv
// One-bit conditional invert followed by a half-add with the running carry.
module complement_bit_cell (
  input  logic bit_i,
  input  logic inv_i,
  input  logic carry_i,
  output logic res_o,
  output logic carry_o
);

  logic x;

  assign x       = bit_i ^ inv_i;
  assign res_o   = x ^ carry_i;
  assign carry_o = x & carry_i;

endmodule

// File: rtl/complement_conv_serial.sv
// Bit-serial, LSB-first converter between sign-magnitude, ones' and two's complement.
// Define COMPLEMENT_OVF_EN to saturate and flag the most-negative input in mode 11.
module complement_conv_serial
  import complement_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] result_q;

  logic last;
  logic sign;
  logic inv;
  logic cell_in;
  logic cell_r;
  logic carry_d;
  logic bit_d;
  logic carry_init;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    last       = 1'b0;
    sign       = 1'b0;
    inv        = 1'b0;
    cell_in    = 1'b0;
    bit_d      = 1'b0;
    carry_init = 1'b0;

    last       = (cnt_q == CNT_W'(WIDTH - 1));
    sign       = a_q[WIDTH-1];
    inv        = (mode_q != MODE_PASS) && sign;
    cell_in    = last ? 1'b0 : a_q[cnt_q];
    // Only mode 10 pushes the sign position through the carry cell; others copy the sign.
    bit_d      = (last && (mode_q != MODE_SM2TC)) ? sign : cell_r;
    carry_init = ((mode == MODE_SM2TC) || (mode == MODE_TC2SM)) && a[WIDTH-1];
  end

  complement_bit_cell u_cell (
    .bit_i   (cell_in),
    .inv_i   (inv),
    .carry_i (carry_q),
    .res_o   (cell_r),
    .carry_o (carry_d)
  );

`ifdef COMPLEMENT_OVF_EN
  logic ovf_q;
  logic ovf_cond;

  // Carry still set entering the sign bit means the magnitude was 2^(WIDTH-1).
  assign ovf_cond = (mode_q == MODE_TC2SM) && carry_q;
  assign ovf      = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_PASS;
      a_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
`ifdef COMPLEMENT_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            a_q     <= a;
            mode_q  <= mode;
            cnt_q   <= '0;
            carry_q <= carry_init;
`ifdef COMPLEMENT_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sh_q    <= {bit_d, sh_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q  <= DONE;
`ifdef COMPLEMENT_OVF_EN
            result_q <= ovf_cond ? '1 : {bit_d, sh_q[WIDTH-1:1]};
            ovf_q    <= ovf_cond;
`else
            result_q <= {bit_d, sh_q[WIDTH-1:1]};
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_complement_conv_serial.sv
// Directed self-checking bench for complement_conv_serial at WIDTH=8.
module tb_complement_conv_serial;
  import complement_pkg::*;

  localparam int WIDTH = 8;

`ifdef COMPLEMENT_OVF_EN
  localparam logic [7:0] MNEG_RES = 8'hFF;
  localparam logic       MNEG_OVF = 1'b1;
`else
  localparam logic [7:0] MNEG_RES = 8'h80;
  localparam logic       MNEG_OVF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;

  complement_conv_serial #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .result (result),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; start is raised immediately, so a call made
  // in a DONE cycle exercises back-to-back acceptance. Returns in the done cycle.
  task automatic do_conv(input string tag, input logic [1:0] m, input logic [7:0] val,
                         input logic [7:0] exp_res, input logic exp_ovf, input int glitch_at);
    int lat;
    int nbusy;
    start = 1'b1;
    mode  = m;
    a     = val;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 30) begin
      if (busy) nbusy++;
      start = (lat == glitch_at);
      if (lat == glitch_at) begin
        a    = 8'h05;
        mode = MODE_PASS;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(WIDTH + 1));
    check({tag, "_busy"}, 32'(nbusy), 32'(WIDTH));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    mode  = MODE_PASS;
    a     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_conv("sm2tc_m5", MODE_SM2TC, 8'h85, 8'hFB, 1'b0, 0);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'h0);
    check("result_hold", 32'(result), 32'hFB);

    do_conv("tc2sm_m5", MODE_TC2SM, 8'hFB, 8'h85, 1'b0, 0);
    do_conv("sm2oc_m5", MODE_SM2OC, 8'h85, 8'hFA, 1'b0, 0);
    do_conv("pass_85", MODE_PASS, 8'h85, 8'h85, 1'b0, 0);
    do_conv("pos_m0", MODE_PASS, 8'h05, 8'h05, 1'b0, 0);
    do_conv("pos_m1", MODE_SM2OC, 8'h05, 8'h05, 1'b0, 0);
    do_conv("pos_m2", MODE_SM2TC, 8'h05, 8'h05, 1'b0, 0);
    do_conv("pos_m3", MODE_TC2SM, 8'h05, 8'h05, 1'b0, 0);
    do_conv("sm2tc_negzero", MODE_SM2TC, 8'h80, 8'h00, 1'b0, 0);
    do_conv("tc2sm_mneg", MODE_TC2SM, 8'h80, MNEG_RES, MNEG_OVF, 0);
    @(posedge clk); #1;
    check("ovf_hold", 32'(ovf), 32'(MNEG_OVF));

    // Mid-run start with a different operand must be ignored; also clears the prior ovf.
    do_conv("glitch", MODE_SM2TC, 8'h85, 8'hFB, 1'b0, 3);
    @(posedge clk); #1;

    do_conv("pre_rst", MODE_TC2SM, 8'h80, MNEG_RES, MNEG_OVF, 0);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = MODE_SM2TC;
    a     = 8'h85;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_ovf", 32'(ovf), 32'h0);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complement_conv_serial.md
# complement_conv_serial

Parametrised, bit-serial sign-representation converter for the PicoVersat ALU datapath. It converts a `WIDTH`-bit operand between sign-magnitude, ones' complement and two's complement, processing one bit per clock LSB-first through a single carry cell. It uses a start/busy/done handshake so the ALU sequencer can chain it ahead of the sum, multiply and division units.

## Interface
- `WIDTH`, default 8: operand/result width in bits; minimum 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle request; samples `a` and `mode`.
- `mode` in 2: conversion mode.
  - 00: pass-through.
  - 01: sign-magnitude to ones' complement.
  - 10: sign-magnitude to two's complement.
  - 11: two's complement to sign-magnitude.
- `a` in `WIDTH`: operand.
- `result` out `WIDTH`: converted value, held until the next completion.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse; `result` and `ovf` are valid from this cycle.
- `ovf` out 1: unrepresentable-input flag (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + `start` → RUN: latch `a`, `mode`; clear bit counter; carry initialised to 1 for modes 10/11 with sign=1, else 0.
  - RUN: process bit `cnt`; increment `cnt`; when `cnt == WIDTH-1` → DONE.
  - DONE without `start` → IDLE.
- `start` during RUN is ignored; `a`/`mode` changes after the start edge are ignored.
- Let s = a[WIDTH-1], inv = s for modes 01/10/11, else 0.
- Bits i < WIDTH-1: x = a[i] XOR inv; r[i] = x XOR carry; carry ← x AND carry.
- MSB, by mode:
  - 00/01/11: r[WIDTH-1] = s.
  - 10: x = 0 XOR inv, processed as a normal bit.
- Corner cases:
  - Mode 10 with sign-magnitude −0 (sign only set) gives all zeros.
  - Mode 11 with the most-negative value gives carry = 1 out of bit WIDTH-2; this is the overflow condition.
- Partial bits accumulate in an internal shift register. `result` and `ovf` load on the RUN→DONE edge only.
- Reset values: `result` = 0, `busy` = 0, `done` = 0, `ovf` = 0, state = IDLE, counter = 0, carry = 0.
- Reset mid-RUN aborts the conversion. No `done` is produced, and `result` returns to 0.

## Timing
- Start sampled at edge k. RUN occupies edges k+1 … k+WIDTH. `done` is high for the cycle after edge k+WIDTH.
- Latency is `WIDTH`+1 cycles from start edge to `done`.
- `busy` = (state == RUN), high for exactly `WIDTH` cycles.
- Back-to-back: `start` asserted in the DONE cycle is accepted. Throughput is one conversion per `WIDTH`+1 cycles.
- `rst` has priority over `start`.

## Configuration
- `COMPLEMENT_OVF_EN`:
  - Defined: in mode 11, if the input is the most-negative two's complement value, `result` saturates to the largest-magnitude negative sign-magnitude value, {1, all ones}, and `ovf` = 1 with `done`.
  - Undefined: `result` = {1, zeros} (−0) and `ovf` is tied to 0.
- `ovf` is cleared at the next accepted `start`, and held otherwise.

## Structure
- Package `complement_pkg` holds:
  - mode constants: `MODE_PASS`, `MODE_SM2OC`, `MODE_SM2TC`, `MODE_TC2SM`;
  - FSM state typedef: IDLE/RUN/DONE.
- Sub-module `complement_bit_cell`: combinational XOR-invert plus half-add of one bit with carry-in. It outputs the result bit and carry-out, and is instantiated once.
- Top level holds the FSM, counter sized `$clog2(WIDTH)`, carry register, shift register and output registers.

## Test plan
All scenarios use `WIDTH`=8.
- Mode 10, `a`=8'h85 (−5 SM) → `result`=8'hFB; `done` exactly 9 cycles after start edge; `busy` high for 8 cycles.
- Mode 11, `a`=8'hFB → 8'h85. Mode 01, `a`=8'h85 → 8'hFA. Mode 00, `a`=8'h85 → 8'h85. Positive `a`=8'h05 in every mode → 8'h05.
- Mode 10, `a`=8'h80 (−0) → 8'h00, `ovf`=0.
- Mode 11, `a`=8'h80:
  - with `COMPLEMENT_OVF_EN` → 8'hFF, `ovf`=1;
  - without → 8'h80, `ovf`=0.
- `start` pulsed mid-RUN with a different `a` → ignored, original result delivered. `start` in the DONE cycle → second conversion completes 9 cycles later.
- `rst` asserted at RUN cycle 4 → next cycle: `busy`=0, `done`=0, `result`=0, `ovf`=0; no `done` pulse follows.
